// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture path (trace_filter feeding trace_buffer):
// opcode classes, trace-entry layout and default sizing.
package trace_pkg;

    localparam int INSTR_WIDTH        = 32;
    localparam int DEFAULT_PC_WIDTH   = 64;
    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_PACKET_LEN = 8;
    localparam int DEFAULT_CNT_WIDTH  = 32;

    // Major opcodes, instr[6:0], as classified by trace_filter.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // One stored trace item at the default PC width; packet end marker in bit 0.
    typedef struct packed {
        logic [INSTR_WIDTH-1:0]      instr;
        logic [DEFAULT_PC_WIDTH-1:0] pc;
        logic                        last;
    } trace_entry_t;

    function automatic int entry_width(input int pc_width);
        return INSTR_WIDTH + pc_width + 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through FIFO. The caller never pops when empty nor pushes when
// full without a pop; mark_last sets bit 0 of the newest entry when there is no push.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   mark_last,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] fill_level
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               LVL_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage is deliberately not reset; validity comes from fill_level alone,
    // so the array can map onto plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end else if (mark_last) begin
            mem[wr_ptr - PTR_ONE][0] <= 1'b1;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop) begin
                fill_level <= fill_level + LVL_ONE;
            end else if (pop && !push) begin
                fill_level <= fill_level - LVL_ONE;
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (fill_level == '0);
    assign full  = (fill_level == LVL_FULL);

endmodule

// File: rtl/trace_buffer.sv
// Captures trace items kept by trace_filter into a FWFT FIFO, streams them out with
// packet boundaries (tlast) and keeps saturating kept/dropped/lost statistics.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int PC_WIDTH   = DEFAULT_PC_WIDTH,
    parameter int PACKET_LEN = DEFAULT_PACKET_LEN,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic [PC_WIDTH-1:0]           in_pc,
    input  logic [INSTR_WIDTH-1:0]        in_instr,
    input  logic                          drop_instr,
    input  logic                          flush,
    input  logic                          clear_stats,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [PC_WIDTH+INSTR_WIDTH-1:0] m_tdata,
    output logic                          m_tlast,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          kept_count,
    output logic [CNT_WIDTH-1:0]          dropped_count,
    output logic [CNT_WIDTH-1:0]          lost_count,
    output logic [$clog2(DEPTH):0]        fill_level
);

    localparam int                   ENTRY_W = entry_width(PC_WIDTH);
    localparam int                   LVL_W   = $clog2(DEPTH) + 1;
    localparam int                   PKT_W   = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [PKT_W-1:0]     PKT_MAX = PKT_W'(PACKET_LEN - 1);
    localparam logic [PKT_W-1:0]     PKT_ONE = PKT_W'(1);
    localparam logic [LVL_W-1:0]     LVL_ONE = LVL_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic               cap, keep, drop_hit, pop, push, lose;
    logic               last_bit, entries_remain, flush_act, mark_last;
    logic               fifo_empty, fifo_full;
    logic [PKT_W-1:0]   pkt_cnt;
    logic               pending_last;
    logic [ENTRY_W-1:0] rdata;

    // A clear in the same cycle as an event leaves the counter at exactly one.
    function automatic logic [CNT_WIDTH-1:0] next_count(input logic [CNT_WIDTH-1:0] cnt,
                                                       input logic inc, input logic clr);
        if (clr) return inc ? CNT_ONE : '0;
        if (inc && (cnt != '1)) return cnt + CNT_ONE;
        return cnt;
    endfunction

    // NOTE: every signal here is assigned on every evaluation, so no latches are inferred.
    always_comb begin
        cap      = en & in_valid;
        keep     = cap & ~drop_instr;
        drop_hit = cap & drop_instr;
        pop      = m_tvalid & m_tready;
        push     = keep & (~fifo_full | pop);
        lose     = keep & fifo_full & ~pop;
        last_bit = (pkt_cnt == PKT_MAX) | flush | pending_last;
        // Whether anything is still queued once this cycle's pop has retired.
        entries_remain = pop ? (fill_level > LVL_ONE) : ~fifo_empty;
        flush_act      = flush & ~push & ((pkt_cnt != '0) | pending_last);
        mark_last      = flush_act & entries_remain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt       <= '0;
            pending_last  <= 1'b0;
            overflow      <= 1'b0;
            kept_count    <= '0;
            dropped_count <= '0;
            lost_count    <= '0;
        end else begin
            kept_count    <= next_count(kept_count, push, clear_stats);
            dropped_count <= next_count(dropped_count, drop_hit, clear_stats);
            lost_count    <= next_count(lost_count, lose, clear_stats);
            overflow      <= lose | (overflow & ~clear_stats);

            if (push) begin
                if (last_bit) begin
                    pkt_cnt      <= '0;
                    pending_last <= 1'b0;
                end else begin
                    pkt_cnt <= pkt_cnt + PKT_ONE;
                end
            end else if (flush_act) begin
                // Nothing left to mark: the next pushed item closes the packet instead.
                pkt_cnt <= '0;
                if (!entries_remain) pending_last <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .wdata      ({in_instr, in_pc, last_bit}),
        .pop        (pop),
        .mark_last  (mark_last),
        .rdata      (rdata),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .fill_level (fill_level)
    );

    assign m_tvalid = ~fifo_empty;
    assign m_tdata  = rdata[ENTRY_W-1:1];
    assign m_tlast  = m_tvalid & rdata[0];

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus random traffic compared
// every cycle against a queue-based reference model.
module tb_trace_buffer;
    import trace_pkg::*;

    localparam int DEPTH      = 16;
    localparam int PC_WIDTH   = 64;
    localparam int PACKET_LEN = 8;
    localparam int CNT_WIDTH  = 8;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;
    localparam logic [31:0] I_BRANCH = 32'h0000_0063;
    localparam logic [31:0] I_ADDI   = 32'h0000_0013;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en = 1'b0, in_valid = 1'b0, drop_instr = 1'b0;
    logic                    flush = 1'b0, clear_stats = 1'b0, m_tready = 1'b0;
    logic [PC_WIDTH-1:0]     in_pc = '0;
    logic [31:0]             in_instr = '0;
    logic                    m_tvalid, m_tlast, overflow;
    logic [PC_WIDTH+31:0]    m_tdata;
    logic [CNT_WIDTH-1:0]    kept_count, dropped_count, lost_count;
    logic [$clog2(DEPTH):0]  fill_level;

    always #5 clk = ~clk;

    trace_buffer #(
        .DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .PACKET_LEN(PACKET_LEN), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_pc(in_pc),
        .in_instr(in_instr), .drop_instr(drop_instr), .flush(flush),
        .clear_stats(clear_stats), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .overflow(overflow),
        .kept_count(kept_count), .dropped_count(dropped_count), .lost_count(lost_count),
        .fill_level(fill_level)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the queue holds exactly what the stream still owes downstream.
    trace_entry_t mq[$];
    int pkt_n, kept, dropped, lost;
    bit pend, ovf;
    int beats, tlast_beats, last_tlast_idx;

    function automatic int sat(input int v, input bit clr, input bit inc);
        if (clr) return inc ? 1 : 0;
        return (inc && v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        mq.delete();
        pkt_n = 0; pend = 0; kept = 0; dropped = 0; lost = 0; ovf = 0;
        beats = 0; tlast_beats = 0; last_tlast_idx = 0;
    endtask

    task automatic check_outputs();
        check("m_tvalid", m_tvalid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("m_tdata", m_tdata, {mq[0].instr, mq[0].pc});
            check("m_tlast", m_tlast, mq[0].last);
        end
        check("fill_level", fill_level, mq.size());
        check("kept_count", kept_count, kept);
        check("dropped_count", dropped_count, dropped);
        check("lost_count", lost_count, lost);
        check("overflow", overflow, ovf);
    endtask

    // One clock cycle: check state, drive inputs, advance the model, move to next negedge.
    task automatic step(input bit s_en, input bit s_valid, input logic [63:0] s_pc,
                        input logic [31:0] s_instr, input bit s_drop, input bit s_flush,
                        input bit s_clr, input bit s_ready);
        bit cap, keep, popm, fullm, pushm, losem, lastb;
        trace_entry_t e;
        check_outputs();
        en = s_en; in_valid = s_valid; in_pc = s_pc; in_instr = s_instr;
        drop_instr = s_drop; flush = s_flush; clear_stats = s_clr; m_tready = s_ready;
        if (m_tvalid && m_tready) begin
            beats++;
            if (m_tlast) begin
                tlast_beats++;
                last_tlast_idx = beats;
            end
        end
        cap   = s_en && s_valid;
        keep  = cap && !s_drop;
        popm  = (mq.size() != 0) && s_ready;
        fullm = (mq.size() == DEPTH);
        pushm = keep && (!fullm || popm);
        losem = keep && fullm && !popm;
        lastb = (pkt_n == PACKET_LEN - 1) || s_flush || pend;
        if (popm) void'(mq.pop_front());
        if (pushm) begin
            e.instr = s_instr; e.pc = s_pc; e.last = lastb;
            mq.push_back(e);
            if (lastb) begin
                pkt_n = 0; pend = 0;
            end else begin
                pkt_n++;
            end
        end else if (s_flush && (pkt_n != 0 || pend)) begin
            if (mq.size() != 0) begin
                e = mq[mq.size() - 1];
                e.last = 1'b1;
                mq[mq.size() - 1] = e;
            end else begin
                pend = 1;
            end
            pkt_n = 0;
        end
        kept    = sat(kept, s_clr, pushm);
        dropped = sat(dropped, s_clr, cap && s_drop);
        lost    = sat(lost, s_clr, losem);
        ovf     = s_clr ? losem : (ovf || losem);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_item(input logic [31:0] instr, input bit ready);
        step(1, 1, {$urandom, $urandom}, instr, instr[6:0] == OPC_OP_IMM, 0, 0, ready);
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) step(1, 0, '0, '0, 0, 0, 0, ready);
    endtask

    task automatic do_reset();
        en = 0; in_valid = 0; drop_instr = 0; flush = 0; clear_stats = 0; m_tready = 0;
        #2 rst_n = 1'b0;
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ready_pct;
        model_reset();
        @(negedge clk);
        do_reset();
        check("reset m_tvalid", m_tvalid, 1'b0);
        check("reset m_tlast", m_tlast, 1'b0);
        check("reset fill_level", fill_level, 0);
        check("reset overflow", overflow, 1'b0);

        // Mixed stream: addi items are filtered out.
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 64'h1000 + 64'(4 * i), (i % 2 == 0) ? I_BRANCH : I_ADDI,
                 (i % 2) == 1, 0, 0, 1);
        end
        idle(3, 1);
        check("mixed beats", beats, 5);
        check("mixed kept", kept_count, 5);
        check("mixed dropped", dropped_count, 5);
        check("mixed tlast", tlast_beats, 0);

        // Packetisation: full packet, then a short packet closed by a flush.
        do_reset();
        for (int i = 0; i < 8; i++) push_item(I_BRANCH, 1);
        idle(3, 1);
        check("pkt beats", beats, 8);
        check("pkt tlast count", tlast_beats, 1);
        check("pkt tlast idx", last_tlast_idx, 8);
        for (int i = 0; i < 3; i++) push_item(I_BRANCH, 0);
        step(1, 0, '0, '0, 0, 1, 0, 0);
        idle(5, 1);
        check("flush beats", beats, 11);
        check("flush tlast count", tlast_beats, 2);
        check("flush tlast idx", last_tlast_idx, 11);

        // Overflow with a stalled sink, then drain in order.
        do_reset();
        for (int i = 0; i < 20; i++) push_item(I_BRANCH, 0);
        check("ovf fill", fill_level, DEPTH);
        check("ovf lost", lost_count, 4);
        check("ovf sticky", overflow, 1'b1);
        idle(20, 1);
        check("ovf drain beats", beats, DEPTH);
        check("ovf drained", fill_level, 0);

        // Full FIFO with simultaneous pop and push: no loss.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_item(I_BRANCH, 0);
        push_item(I_BRANCH, 1);
        check("full+pop fill", fill_level, DEPTH);
        check("full+pop lost", lost_count, 0);
        idle(DEPTH + 2, 1);

        // Flush on an empty FIFO mid-packet: next item closes the packet.
        do_reset();
        for (int i = 0; i < 3; i++) push_item(I_BRANCH, 1);
        idle(3, 1);
        step(1, 0, '0, '0, 0, 1, 0, 1);
        check("empty flush beats", beats, 3);
        push_item(I_BRANCH, 1);
        idle(3, 1);
        check("pend beats", beats, 4);
        check("pend tlast count", tlast_beats, 1);
        check("pend tlast idx", last_tlast_idx, 4);

        // Saturation and clear_stats coinciding with events.
        do_reset();
        for (int i = 0; i < 300; i++) step(1, 1, '0, I_ADDI, 1, 0, 0, 1);
        check("sat dropped", dropped_count, CNT_MAX);
        step(1, 1, '0, I_ADDI, 1, 0, 1, 1);
        check("clr+drop", dropped_count, 1);
        for (int i = 0; i < DEPTH + 1; i++) push_item(I_BRANCH, 0);
        step(1, 1, '0, I_BRANCH, 0, 0, 1, 0);
        check("clr+loss lost", lost_count, 1);
        check("clr+loss ovf", overflow, 1'b1);
        step(1, 0, '0, '0, 0, 0, 1, 0);
        check("clr ovf", overflow, 1'b0);
        check("clr lost", lost_count, 0);

        // Asynchronous reset between edges with items queued.
        do_reset();
        for (int i = 0; i < 5; i++) push_item(I_BRANCH, 0);
        check("pre-reset fill", fill_level, 5);
        #2 rst_n = 1'b0;
        #1;
        check("async m_tvalid", m_tvalid, 1'b0);
        check("async fill", fill_level, 0);
        check("async kept", kept_count, 0);
        check("async overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Random traffic against the model.
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] instr;
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ready_pct = 15;
                    1:       ready_pct = 50;
                    default: ready_pct = 95;
                endcase
            end
            instr = $urandom;
            step(($urandom % 8) != 0, ($urandom % 4) != 0, {$urandom, $urandom}, instr,
                 ($urandom % 3) == 0, ($urandom % 16) == 0, ($urandom % 1500) == 0,
                 $urandom_range(0, 99) < ready_pct);
        end
        idle(DEPTH + 4, 1);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Sits directly downstream of trace_filter: captures every trace item the filter keeps (drop_instr=0) and queues it for the host-side export path.
- Kept items are written into a first-word-fall-through FIFO and presented on an AXI-Stream-style master interface with packetisation (tlast).
- Items the filter drops, and items lost to overflow, are counted in saturating counters for software visibility.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- PC_WIDTH, 64, width of the traced program counter.
- PACKET_LEN, 8, kept items per stream packet; >= 1.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; 0 = no writes, no counter updates.
- in_valid  input  1  trace item present this cycle.
- in_pc  input  PC_WIDTH  PC of the traced instruction.
- in_instr  input  32  traced instruction word; also drives trace_filter.instr.
- drop_instr  input  1  trace_filter verdict for in_instr, same cycle, combinational.
- flush  input  1  close the current packet.
- clear_stats  input  1  zero the counters and overflow.
- m_tvalid  output  1  stream data valid.
- m_tready  input  1  downstream ready.
- m_tdata  output  PC_WIDTH+32  {in_instr, in_pc}.
- m_tlast  output  1  last item of packet.
- overflow  output  1  sticky: at least one kept item was lost.
- kept_count  output  CNT_WIDTH  items written into the FIFO.
- dropped_count  output  CNT_WIDTH  items rejected by the filter.
- lost_count  output  CNT_WIDTH  kept items lost because the FIFO was full.
- fill_level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): pointers, fill_level, packet counter and pending_last = 0; m_tvalid=0, m_tlast=0, overflow=0; all counters 0; FIFO contents don't-care.
- Definitions:
  - cap = en & in_valid.
  - keep = cap & ~drop_instr.
  - pop = m_tvalid & m_tready.
- Push:
  - keep & (fill_level<DEPTH | pop) writes {in_instr, in_pc, last_bit}. A full FIFO with a simultaneous pop accepts the write.
  - kept_count increments on every push.
- Loss: keep when the FIFO is full and pop=0 → item discarded, lost_count increments, overflow=1 (sticky).
- Filtered: cap & drop_instr → dropped_count increments, nothing written.
- Counters saturate at all-ones.
- clear_stats zeroes counters and overflow. If an increment occurs in the same cycle, the counter becomes 1, and overflow=1 if a loss occurs that cycle.
- Latency: a pushed item appears on m_tdata/m_tvalid the next cycle (FWFT; output read from the rd_ptr entry).
- m_tdata/m_tlast hold stable while m_tvalid & ~m_tready.
- fill_level is the registered occupancy: +1 push, -1 pop, unchanged if both or neither.
- Packetisation, on the write side, via pkt_cnt (0..PACKET_LEN-1) counting pushes in the current packet:
  - last_bit = (pkt_cnt==PACKET_LEN-1) | flush | pending_last.
  - A push with last_bit=1 resets pkt_cnt to 0 and clears pending_last; otherwise pkt_cnt increments.
  - flush without a push, with entries remaining after this cycle's pop: set last_bit of the newest entry (wr_ptr-1) and reset pkt_cnt.
  - flush without a push and no remaining entries: set pending_last (the next pushed item gets last=1) and reset pkt_cnt. If pkt_cnt was already 0 and pending_last was clear, flush is ignored.
- Pointers wrap modulo DEPTH; full/empty is derived from fill_level.
- en=0 mid-stream: the FIFO keeps draining, counters freeze; flush is still honoured.
- Reset mid-operation: contents are discarded and the output goes invalid immediately (async).

Decomposition:
- Package trace_pkg:
  - opcode constants shared with trace_filter.
  - trace-entry struct/width constants: PC_WIDTH, entry = instr+pc+last.
  - default PACKET_LEN.
- Sub-module trace_fifo: generic FWFT FIFO with push/pop/fill_level and a "mark newest" port for the flush retro-marking.
- trace_buffer holds the counters, packetiser and loss logic.

Test Plan:
- Mixed stream, PACKET_LEN=8, m_tready=1: 10 items alternating branch (0x00000063) and addi (0x00000013) → 5 stream beats with the correct {instr,pc}; kept_count=5, dropped_count=5; no tlast (pkt_cnt=5).
- Packetisation: 8 consecutive kept items → tlast on the 8th beat only. Next 3 items, then a flush with no push → tlast on the 3rd.
- Overflow, DEPTH=16, m_tready=0: 20 kept items → fill_level=16, lost_count=4, overflow=1. m_tready=1 → exactly 16 beats out, in order.
- Full plus simultaneous pop/push: FIFO full, m_tready=1 and keep in the same cycle → no loss, fill_level stays 16, lost_count unchanged.
- Flush on empty FIFO: flush with the FIFO empty and pkt_cnt=3 → nothing emitted; the next kept item emerges with tlast=1.
- Async reset with 5 entries queued and m_tready=0: assert rst_n=0 between edges → m_tvalid=0 and fill_level=0 immediately; counters 0; overflow=0.
